// File: rtl/ecdh_session_ctrl_pkg.sv
// ECDH session controller shared types: operand width, curve base point,
// FSM states, op codes and response error codes.
package ecdh_session_ctrl_pkg;

  localparam int BW_GF = 192;

  // NIST P-192 generator
  localparam logic [BW_GF-1:0] GX =
    192'h188da80eb03090f67cbf20eb43a18800f4ff0afd82ff1012;
  localparam logic [BW_GF-1:0] GY =
    192'h07192b95ffc8da78631011ed6b24cdd573f977a11e794811;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic OP_KEYGEN = 1'b0;
  localparam logic OP_SHARED = 1'b1;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_ZERO = 2'd1;
  localparam logic [1:0] ERR_WDOG = 2'd2;

endpackage

// File: rtl/ecdh_session_ctrl.sv
// ECDH job initiator for the EC scalar-multiply engine (KEYGEN / SHARED).
// Optional watchdog on the engine wait: define ECDH_WATCHDOG_EN.
module ecdh_session_ctrl
  import ecdh_session_ctrl_pkg::*;
#(
  parameter int BW = BW_GF,
  parameter logic [31:0] WDOG_MAX = 32'hFFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_op,
  input  logic [BW-1:0] req_key,
  input  logic [BW-1:0] req_px,
  input  logic [BW-1:0] req_py,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [BW-1:0] resp_x,
  output logic [BW-1:0] resp_y,
  output logic [1:0]    resp_err,
  output logic          sm_start,
  output logic [BW-1:0] sm_k,
  output logic [BW-1:0] sm_px,
  output logic [BW-1:0] sm_py,
  input  logic [BW-1:0] sm_qx,
  input  logic [BW-1:0] sm_qy,
  input  logic          sm_valid
);

  state_t state;

`ifdef ECDH_WATCHDOG_EN
  logic [31:0] wdog;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_x     <= '0;
      resp_y     <= '0;
      resp_err   <= ERR_OK;
      sm_start   <= 1'b0;
      sm_k       <= '0;
      sm_px      <= '0;
      sm_py      <= '0;
`ifdef ECDH_WATCHDOG_EN
      wdog       <= '0;
`endif
    end else begin
      sm_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            sm_k      <= req_key;
            if (req_op == OP_SHARED) begin
              sm_px <= req_px;
              sm_py <= req_py;
            end else begin
              sm_px <= BW'(GX);
              sm_py <= BW'(GY);
            end
            if (req_key == '0) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= ERR_ZERO;
              resp_x     <= '0;
              resp_y     <= '0;
            end else begin
              state    <= ST_ISSUE;
              sm_start <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
`ifdef ECDH_WATCHDOG_EN
          wdog  <= '0;
`endif
        end
        ST_WAIT: begin
          if (sm_valid) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_x     <= sm_qx;
            resp_y     <= sm_qy;
            resp_err   <= ERR_OK;
`ifdef ECDH_WATCHDOG_EN
          end else if (wdog == WDOG_MAX - 32'd1) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_x     <= '0;
            resp_y     <= '0;
            resp_err   <= ERR_WDOG;
          end else begin
            wdog <= wdog + 32'd1;
`endif
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecdh_session_ctrl.sv
// Randomized bench for ecdh_session_ctrl with a behavioural engine stub
// whose toy group law is Q = k*P component-wise mod 2^192.
module tb_ecdh_session_ctrl;

  localparam int BW = 192;
  localparam logic [BW-1:0] TGX =
    192'h188da80eb03090f67cbf20eb43a18800f4ff0afd82ff1012;
  localparam logic [BW-1:0] TGY =
    192'h07192b95ffc8da78631011ed6b24cdd573f977a11e794811;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_op;
  logic [BW-1:0] req_key, req_px, req_py;
  logic          resp_valid, resp_ready;
  logic [BW-1:0] resp_x, resp_y;
  logic [1:0]    resp_err;
  logic          sm_start, sm_valid;
  logic [BW-1:0] sm_k, sm_px, sm_py, sm_qx, sm_qy;

  ecdh_session_ctrl #(.WDOG_MAX(32'd100)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_key(req_key),
    .req_px(req_px), .req_py(req_py),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_x(resp_x), .resp_y(resp_y), .resp_err(resp_err),
    .sm_start(sm_start), .sm_k(sm_k),
    .sm_px(sm_px), .sm_py(sm_py),
    .sm_qx(sm_qx), .sm_qy(sm_qy), .sm_valid(sm_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [BW-1:0] got,
                     input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom()};
  endfunction

  bit eng_mute = 0, eng_double = 0, stray_req = 0, unstable = 0;
  int eng_lat_fix = 0;
  int starts = 0, start_cyc = 0, valid_cyc = 0;

  initial begin
    int cnt, dbl;
    bit busy;
    logic [BW-1:0] ek, ex, ey;
    sm_valid = 0; sm_qx = '0; sm_qy = '0;
    busy = 0; cnt = 0; dbl = 0;
    forever begin
      @(negedge clk);
      sm_valid = 0;
      if (rst) begin
        busy = 0; dbl = 0;
        continue;
      end
      if (stray_req) begin
        stray_req = 0;
        sm_valid = 1; sm_qx = rnd(); sm_qy = rnd();
        continue;
      end
      if (sm_start) begin
        starts++; start_cyc = cyc; busy = 1;
        ek = sm_k; ex = sm_px; ey = sm_py;
        cnt = (eng_lat_fix > 0) ? eng_lat_fix : $urandom_range(1, 20);
      end else if (busy) begin
        if (sm_k !== ek || sm_px !== ex || sm_py !== ey) unstable = 1;
        if (!eng_mute) begin
          cnt--;
          if (cnt == 0) begin
            busy = 0; sm_valid = 1;
            sm_qx = ek * ex; sm_qy = ek * ey;
            valid_cyc = cyc;
            dbl = eng_double ? 2 : 0;
          end
        end
      end else if (dbl > 0) begin
        dbl--;
        if (dbl == 0) begin
          sm_valid = 1; sm_qx = ~sm_qx; sm_qy = ~sm_qy;
        end
      end
    end
  end

  task automatic do_job(input bit op, input logic [BW-1:0] key,
                        input logic [BW-1:0] px, input logic [BW-1:0] py,
                        input int hold,
                        output logic [BW-1:0] rx, output logic [BW-1:0] ry);
    logic [BW-1:0] bx, by, ex_x, ex_y, hx, hy;
    logic [1:0] ex_e, he;
    int s0, acc, t;
    bit bad;
    bx = op ? px : TGX;
    by = op ? py : TGY;
    if (key == '0) begin
      ex_x = '0; ex_y = '0; ex_e = 2'd1;
    end else begin
      ex_x = key * bx; ex_y = key * by; ex_e = 2'd0;
    end
    s0 = starts; unstable = 0;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_op = op; req_key = key;
    req_px = px; req_py = py; acc = cyc;
    @(negedge clk);
    req_valid = 0; req_key = rnd(); req_px = rnd(); req_py = rnd();
    chk("req_ready_drop", req_ready, 0);
    t = 0;
    while (!resp_valid && t < 300) begin
      @(negedge clk); t++;
    end
    chk("resp_seen", resp_valid, 1);
    if (key == '0) begin
      chk("zero_lat", BW'(cyc - acc <= 2), 1);
      chk("zero_nostart", BW'(starts - s0), 0);
    end else begin
      chk("one_start", BW'(starts - s0), 1);
      chk("start_lat", BW'(start_cyc - acc), 1);
      chk("resp_lat", BW'(cyc - valid_cyc), 1);
      chk("operand_stable", BW'(unstable), 0);
    end
    chk("resp_x", resp_x, ex_x);
    chk("resp_y", resp_y, ex_y);
    chk("resp_err", BW'(resp_err), BW'(ex_e));
    rx = resp_x; ry = resp_y;
    hx = resp_x; hy = resp_y; he = resp_err; bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (resp_x !== hx || resp_y !== hy || resp_err !== he ||
          resp_valid !== 1'b1 || req_ready !== 1'b0) bad = 1;
    end
    if (hold > 0) chk("resp_hold", BW'(bad), 0);
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    chk("resp_drop", resp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  initial begin
    logic [BW-1:0] ax, ay, bx, by;
    bit bad;
    int t;
    rst = 1; req_valid = 0; req_op = 0; req_key = '0;
    req_px = '0; req_py = '0; resp_ready = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_sm_start", sm_start, 0);
    chk("rst_resp_x", resp_x, 0);
    chk("rst_resp_y", resp_y, 0);
    chk("rst_resp_err", BW'(resp_err), 0);
    chk("rst_sm_k", sm_k, 0);
    chk("rst_sm_px", sm_px, 0);
    chk("rst_sm_py", sm_py, 0);

    do_job(1'b0, BW'(1), rnd(), rnd(), 0, ax, ay);
    chk("t1_gx", ax, TGX);
    chk("t1_gy", ay, TGY);

    do_job(1'b0, BW'(2), rnd(), rnd(), 1, ax, ay);
    do_job(1'b1, BW'(3), ax, ay, 2, bx, by);
    chk("t2_6gx", bx, TGX * BW'(6));
    chk("t2_6gy", by, TGY * BW'(6));

    do_job(1'b1, '0, rnd(), rnd(), 0, ax, ay);

    eng_double = 1;
    do_job(1'b1, rnd(), rnd(), rnd(), 50, ax, ay);
    eng_double = 0;

    eng_lat_fix = 30;
    req_valid = 1; req_op = 0; req_key = rnd();
    @(negedge clk);
    req_valid = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    eng_lat_fix = 0;
    chk("t5_req_ready", req_ready, 1);
    chk("t5_resp_valid", resp_valid, 0);
    stray_req = 1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad = 1;
    end
    chk("t5_stray_ignored", BW'(bad), 0);
    do_job(1'b0, BW'(5), rnd(), rnd(), 0, ax, ay);
    chk("t5_5gx", ax, TGX * BW'(5));

    for (int i = 0; i < 24; i++) begin
      logic [BW-1:0] k;
      k = ($urandom_range(0, 5) == 0) ? '0 : rnd();
      eng_double = $urandom_range(0, 3) == 0;
      do_job(1'($urandom_range(0, 1)), k, rnd(), rnd(),
             $urandom_range(0, 5), ax, ay);
    end
    eng_double = 0;

`ifdef ECDH_WATCHDOG_EN
    eng_mute = 1;
    req_valid = 1; req_op = 1; req_key = rnd();
    req_px = rnd(); req_py = rnd();
    @(negedge clk);
    req_valid = 0;
    t = 0;
    while (!resp_valid && t < 400) begin
      @(negedge clk); t++;
    end
    chk("t6_resp_seen", resp_valid, 1);
    chk("t6_wdog_lat", BW'(cyc - start_cyc), BW'(101));
    chk("t6_err", BW'(resp_err), BW'(2));
    chk("t6_x", resp_x, 0);
    chk("t6_y", resp_y, 0);
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    chk("t6_req_ready", req_ready, 1);
    eng_mute = 0;
`else
    t = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
